// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM handshake state, arbiter FSM states
// and the latched RAM request payload.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IREQ  = 3'd1,
    DREQ  = 3'd2,
    IDONE = 3'd3,
    DDONE = 3'd4,
    ERR   = 3'd5
  } arb_state_t;

  typedef struct packed {
    word_t addr;
    word_t store;
    logic  wr;
  } ram_req_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data ports onto a single RAM; data wins ties,
// and a stalled access is aborted after TIMEOUT counted wait cycles.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter word_t       BADWORD = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      merr,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  ram_req_t         req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            iload_q, iload_d;
  word_t            dload_q, dload_d;
  logic             abort_data_q, abort_data_d;

  // Next-state and RAM-side outputs; strobes come only from the latched request.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    iload_d      = iload_q;
    dload_d      = dload_q;
    abort_data_d = abort_data_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;

    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d = DREQ;
          req_d   = '{addr: daddr, store: dstore, wr: dWEN};
          cnt_d   = '0;
        end else if (iREN) begin
          state_d = IREQ;
          req_d   = '{addr: iaddr, store: '0, wr: 1'b0};
          cnt_d   = '0;
        end
      end
      IREQ, DREQ: begin
        ramaddr  = req_q.addr;
        ramstore = req_q.store;
        ramWEN   = req_q.wr;
        ramREN   = !req_q.wr;
        if (ramstate == ACCESS) begin
          state_d = (state_q == IREQ) ? IDONE : DDONE;
          if (!req_q.wr) begin
            if (state_q == IREQ) iload_d = ramload;
            else                 dload_d = ramload;
          end
        end else if (ramstate == ERROR || cnt_q == CNT_W'(TIMEOUT)) begin
          state_d      = ERR;
          abort_data_d = (state_q == DREQ);
          if (state_q == DREQ) dload_d = BADWORD;
          else                 iload_d = BADWORD;
        end else begin
          // Leaving this branch at cnt_q == TIMEOUT keeps the counter saturated.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDONE, DDONE, ERR: state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Port-side handshake: a wait drops only in the completing or aborting cycle.
  assign iwait = iREN && !((state_q == IDONE) || (state_q == ERR && !abort_data_q));
  assign dwait = (dREN || dWEN) && !((state_q == DDONE) || (state_q == ERR && abort_data_q));
  assign merr  = (state_q == ERR);
  assign iload = iload_q;
  assign dload = dload_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      iload_q      <= '0;
      dload_q      <= '0;
      abort_data_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      iload_q      <= iload_d;
      dload_q      <= dload_d;
      abort_data_q <= abort_data_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboarded bench for memory_arbiter with a behavioural RAM responder.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned TO  = 4;
  localparam word_t       BAD = 32'hBAD1BAD1;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait, merr, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  typedef struct { logic is_d; word_t load; } exp_t;
  typedef struct { logic wen; word_t addr; word_t store; } strobe_t;

  exp_t    sb[$];
  strobe_t slog[$];
  word_t   mem [word_t];
  int      vectors = 0;
  int      miscompares = 0;
  int      ram_busy_n = 0;
  int      ram_mode = 0;
  int      busy_cnt = 0;

  memory_arbiter #(.TIMEOUT(TO), .BADWORD(BAD)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .merr(merr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  function automatic word_t mem_rd(word_t a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  // RAM responder: mode 0 = BUSY for ram_busy_n cycles then ACCESS,
  // mode 1 = stuck BUSY, mode 2 = ERROR.
  initial begin
    ramstate = FREE;
    ramload  = '0;
    forever begin
      @(negedge CLK);
      vectors++;
      if (ramREN && ramWEN) begin
        miscompares++;
        $display("FAIL strobe_onehot: ramREN=%b ramWEN=%b, required at most one high", ramREN, ramWEN);
      end
      if (ramREN || ramWEN) begin
        if (busy_cnt == 0) slog.push_back('{ramWEN, ramaddr, ramstore});
        if (ram_mode == 2) ramstate = ERROR;
        else if (ram_mode == 1 || busy_cnt < ram_busy_n) ramstate = BUSY;
        else begin
          ramstate = ACCESS;
          ramload  = mem_rd(ramaddr);
          if (ramWEN) mem[ramaddr] = ramstore;
        end
        busy_cnt++;
      end else begin
        ramstate = FREE;
        busy_cnt = 0;
      end
    end
  end

  task automatic test_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
    repeat (3) @(negedge CLK);
    vectors++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin miscompares++; $display("FAIL reset_strobes: got %b%b expected 00", ramREN, ramWEN); end
    vectors++; if (iload !== '0 || dload !== '0) begin miscompares++; $display("FAIL reset_loads: got %h/%h expected 0/0", iload, dload); end
    vectors++; if (merr !== 1'b0 || ramaddr !== '0) begin miscompares++; $display("FAIL reset_merr_addr: got %b/%h expected 0/0", merr, ramaddr); end
    nRST = 1'b1;
  endtask

  task automatic test_data_read();
    exp_t e; int cyc = 0;
    ram_mode = 0; ram_busy_n = 0;
    @(negedge CLK);
    dREN = 1; daddr = 32'h40;
    sb.push_back('{1'b1, 32'h12345678});
    do begin
      @(negedge CLK); cyc++;
      if (cyc == 1) begin
        vectors++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin miscompares++; $display("FAIL rd_strobe: got ren=%b wen=%b addr=%h expected 1 0 00000040", ramREN, ramWEN, ramaddr); end
      end
    end while (dwait === 1'b1 && cyc < 20);
    dREN = 0;
    e = sb.pop_front();
    vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL rd_latency: got %0d expected 2", cyc); end
    vectors++; if (dload !== e.load) begin miscompares++; $display("FAIL rd_dload: got %h expected %h", dload, e.load); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int cyc = 0; int dcyc;
    ram_mode = 0; ram_busy_n = 2; slog.delete();
    @(negedge CLK);
    iREN = 1; iaddr = 32'h100; dWEN = 1; daddr = 32'h80; dstore = 32'hCAFEF00D;
    sb.push_back('{1'b0, 32'hFFFFFEFF});
    do begin
      @(negedge CLK); cyc++;
      vectors++; if (iwait !== 1'b1) begin miscompares++; $display("FAIL b2b_iwait_hold cyc %0d: got %b expected 1", cyc, iwait); end
    end while (dwait === 1'b1 && cyc < 20);
    dcyc = cyc;
    dWEN = 0;
    vectors++; if (dcyc !== 4) begin miscompares++; $display("FAIL b2b_write_latency: got %0d expected 4", dcyc); end
    vectors++; if (dload !== 32'h12345678) begin miscompares++; $display("FAIL b2b_write_no_load: got %h expected 12345678", dload); end
    do begin @(negedge CLK); cyc++; end while (iwait === 1'b1 && cyc < 40);
    iREN = 0;
    e = sb.pop_front();
    vectors++; if (cyc !== 9) begin miscompares++; $display("FAIL b2b_fetch_latency: got %0d expected 9", cyc); end
    vectors++; if (iload !== e.load) begin miscompares++; $display("FAIL b2b_iload: got %h expected %h", iload, e.load); end
    vectors++; if (slog.size() != 2) begin miscompares++; $display("FAIL b2b_strobe_count: got %0d expected 2", slog.size()); end
    else begin
      vectors++; if (slog[0].wen !== 1'b1 || slog[0].addr !== 32'h80 || slog[0].store !== 32'hCAFEF00D) begin miscompares++; $display("FAIL b2b_first_write: got %b %h %h expected 1 00000080 cafef00d", slog[0].wen, slog[0].addr, slog[0].store); end
      vectors++; if (slog[1].wen !== 1'b0 || slog[1].addr !== 32'h100) begin miscompares++; $display("FAIL b2b_second_fetch: got %b %h expected 0 00000100", slog[1].wen, slog[1].addr); end
    end
  endtask

  task automatic test_read_write_both();
    exp_t e; int cyc = 0;
    ram_mode = 0; ram_busy_n = 0;
    @(negedge CLK);
    dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h11112222;
    @(negedge CLK);
    vectors++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h11112222) begin miscompares++; $display("FAIL rw_as_write: got wen=%b ren=%b store=%h expected 1 0 11112222", ramWEN, ramREN, ramstore); end
    @(negedge CLK);
    dWEN = 0; dREN = 0;
    @(negedge CLK);
    dREN = 1;
    sb.push_back('{1'b1, 32'h11112222});
    do begin @(negedge CLK); cyc++; end while (dwait === 1'b1 && cyc < 20);
    dREN = 0;
    e = sb.pop_front();
    vectors++; if (dload !== e.load) begin miscompares++; $display("FAIL rw_readback: got %h expected %h", dload, e.load); end
  endtask

  task automatic test_timeout();
    exp_t e; int cyc = 0;
    ram_mode = 1;
    @(negedge CLK);
    dREN = 1; daddr = 32'h300;
    sb.push_back('{1'b1, BAD});
    do begin
      @(negedge CLK); cyc++;
      if (dwait === 1'b1) begin
        vectors++; if (merr !== 1'b0) begin miscompares++; $display("FAIL to_early_merr cyc %0d: got %b expected 0", cyc, merr); end
      end
    end while (dwait === 1'b1 && cyc < 30);
    e = sb.pop_front();
    vectors++; if (cyc !== 6) begin miscompares++; $display("FAIL to_latency: got %0d expected 6", cyc); end
    vectors++; if (merr !== 1'b1 || dload !== e.load) begin miscompares++; $display("FAIL to_abort: got merr=%b dload=%h expected 1 %h", merr, dload, e.load); end
    @(negedge CLK);
    vectors++; if (merr !== 1'b0 || dwait !== 1'b1 || ramREN !== 1'b0) begin miscompares++; $display("FAIL to_after: got merr=%b dwait=%b ren=%b expected 0 1 0", merr, dwait, ramREN); end
    dREN = 0;
    ram_mode = 0;
  endtask

  task automatic test_ram_error();
    exp_t e; int cyc = 0;
    ram_mode = 2;
    @(negedge CLK);
    iREN = 1; iaddr = 32'h400;
    sb.push_back('{1'b0, BAD});
    do begin @(negedge CLK); cyc++; end while (iwait === 1'b1 && cyc < 20);
    iREN = 0;
    e = sb.pop_front();
    vectors++; if (cyc !== 2 || merr !== 1'b1 || iload !== e.load) begin miscompares++; $display("FAIL err_abort: got cyc=%0d merr=%b iload=%h expected 2 1 %h", cyc, merr, iload, e.load); end
    vectors++; if (dwait !== 1'b0) begin miscompares++; $display("FAIL err_dwait: got %b expected 0", dwait); end
    ram_mode = 0;
    @(negedge CLK);
    vectors++; if (merr !== 1'b0 || ramREN !== 1'b0) begin miscompares++; $display("FAIL err_to_idle: got merr=%b ren=%b expected 0 0", merr, ramREN); end
  endtask

  task automatic test_deassert();
    exp_t e;
    ram_mode = 0; ram_busy_n = 2;
    @(negedge CLK);
    dREN = 1; daddr = 32'h500;
    sb.push_back('{1'b1, 32'hFFFFFAFF});
    @(negedge CLK);
    dREN = 0;
    @(negedge CLK);
    vectors++; if (ramREN !== 1'b1 || dwait !== 1'b0) begin miscompares++; $display("FAIL deassert_continue: got ren=%b dwait=%b expected 1 0", ramREN, dwait); end
    repeat (3) @(negedge CLK);
    e = sb.pop_front();
    vectors++; if (dload !== e.load || merr !== 1'b0) begin miscompares++; $display("FAIL deassert_load: got %h merr=%b expected %h 0", dload, merr, e.load); end
  endtask

  task automatic test_reset_mid();
    exp_t e; int cyc = 0;
    ram_mode = 1;
    @(negedge CLK);
    dREN = 1; daddr = 32'h600;
    repeat (2) @(negedge CLK);
    vectors++; if (ramREN !== 1'b1) begin miscompares++; $display("FAIL mid_pre_strobe: got %b expected 1", ramREN); end
    nRST = 1'b0;
    #1;
    vectors++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== '0) begin miscompares++; $display("FAIL mid_reset_strobes: got %b%b %h expected 00 0", ramREN, ramWEN, ramaddr); end
    vectors++; if (dload !== '0 || iload !== '0 || merr !== 1'b0) begin miscompares++; $display("FAIL mid_reset_outs: got %h %h %b expected 0 0 0", dload, iload, merr); end
    dREN = 0;
    ram_mode = 0; ram_busy_n = 0;
    @(negedge CLK);
    nRST = 1'b1; dREN = 1; daddr = 32'h40;
    sb.push_back('{1'b1, 32'h12345678});
    do begin @(negedge CLK); cyc++; end while (dwait === 1'b1 && cyc < 20);
    dREN = 0;
    e = sb.pop_front();
    vectors++; if (cyc !== 2 || dload !== e.load) begin miscompares++; $display("FAIL post_reset_req: got cyc=%0d dload=%h expected 2 %h", cyc, dload, e.load); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h40] = 32'h12345678;
    test_reset();
    test_data_read();
    test_back_to_back();
    test_read_write_both();
    test_timeout();
    test_ram_error();
    test_deassert();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
